// File: rtl/ym_dac_decoder.sv
// YM3014-format serial DAC decoder for two YM2203 chips: deserialises, converts
// floating-point frames to 16-bit signed linear, mixes with saturation, valid/ready out.
module ym_dac_decoder #(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               fclk,
    input  logic               ayres,
    input  logic               bit_en,
    input  logic               op1,
    input  logic               op2,
    input  logic               sh,
    input  logic               fm_mute,
    input  logic               smp_ready,
    output logic               smp_valid,
    output logic signed [15:0] smp1,
    output logic signed [15:0] smp2,
    output logic signed [15:0] smp_mix,
    output logic               overrun,
    output logic               frame_err
);

    localparam int         DATA_W   = 16;
    localparam logic [3:0] CNT_LAST = 4'(FRAME_BITS - 1);

    function automatic logic signed [DATA_W-1:0] ym_to_linear(input logic [12:0] fr);
        logic [2:0]               e;
        logic signed [9:0]        m;
        logic signed [DATA_W-1:0] ext;
        e   = fr[12:10];
        m   = {~fr[9], fr[8:0]};
        ext = {{(DATA_W - 10){m[9]}}, m};
        if (e == 3'd0)
            return '0;
        return ext <<< (e - 3'd1);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [DATA_W:0] v);
        if (v > 17'sd32767)
            return 16'sh7FFF;
        if (v < -17'sd32768)
            return 16'sh8000;
        return v[DATA_W-1:0];
    endfunction

    logic [SYNC_STAGES-1:0] op1_sync_q, op2_sync_q, sh_sync_q, ben_dly_q;
    logic                   op1_s, op2_s, sh_s, ben_s;

    logic [FRAME_BITS-1:0]  sr1_q, sr1_d, sr2_q, sr2_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   latch_q, latch_d;
    logic                   ferr_q, ferr_d;

    logic signed [DATA_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic                     conv_vld_q;

    logic signed [DATA_W:0]   mix_sum;
    logic signed [DATA_W-1:0] out1_q, out2_q, outm_q, outm_d;
    logic                     vld_q, vld_d, ovr_q, ovr_d;
    logic                     pad_unused;

    // Input synchronizers; bit_en rides an equal-length delay so it stays aligned with data
    always_ff @(posedge fclk) begin
        if (ayres) begin
            op1_sync_q <= '0;
            op2_sync_q <= '0;
            sh_sync_q  <= '0;
            ben_dly_q  <= '0;
        end else begin
            op1_sync_q[0] <= op1;
            op2_sync_q[0] <= op2;
            sh_sync_q[0]  <= sh;
            ben_dly_q[0]  <= bit_en;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                op1_sync_q[i] <= op1_sync_q[i-1];
                op2_sync_q[i] <= op2_sync_q[i-1];
                sh_sync_q[i]  <= sh_sync_q[i-1];
                ben_dly_q[i]  <= ben_dly_q[i-1];
            end
        end
    end

    assign op1_s = op1_sync_q[SYNC_STAGES-1];
    assign op2_s = op2_sync_q[SYNC_STAGES-1];
    assign sh_s  = sh_sync_q[SYNC_STAGES-1];
    assign ben_s = ben_dly_q[SYNC_STAGES-1];

    // Deserialiser and frame framing check
    always_comb begin
        sr1_d   = sr1_q;
        sr2_d   = sr2_q;
        cnt_d   = cnt_q;
        latch_d = 1'b0;
        ferr_d  = ferr_q;
        if (ben_s) begin
            sr1_d = {op1_s, sr1_q[FRAME_BITS-1:1]};
            sr2_d = {op2_s, sr2_q[FRAME_BITS-1:1]};
            if (sh_s) begin
                cnt_d = '0;
                if (cnt_q == CNT_LAST)
                    latch_d = 1'b1;
                else
                    ferr_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                ferr_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge fclk) begin
        if (ayres) begin
            sr1_q   <= '0;
            sr2_q   <= '0;
            cnt_q   <= '0;
            latch_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sr1_q   <= sr1_d;
            sr2_q   <= sr2_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            ferr_q  <= ferr_d;
        end
    end

    // The three pad bits carry no information
    assign pad_unused = ^{sr1_q[2:0], sr2_q[2:0]};

    // Float-to-linear conversion stage
    assign s1_d = fm_mute ? '0 : ym_to_linear(sr1_q[15:3]);
    assign s2_d = fm_mute ? '0 : ym_to_linear(sr2_q[15:3]);

    always_ff @(posedge fclk) begin
        if (ayres) begin
            s1_q       <= '0;
            s2_q       <= '0;
            conv_vld_q <= 1'b0;
        end else begin
            if (latch_q) begin
                s1_q <= s1_d;
                s2_q <= s2_d;
            end
            conv_vld_q <= latch_q;
        end
    end

    // Mix and output handshake stage
    assign mix_sum = {s1_q[DATA_W-1], s1_q} + {s2_q[DATA_W-1], s2_q};
    assign outm_d  = sat16(mix_sum);

    always_comb begin
        vld_d = vld_q;
        ovr_d = ovr_q;
        if (conv_vld_q) begin
            vld_d = 1'b1;
            if (vld_q && !smp_ready)
                ovr_d = 1'b1;
        end else if (vld_q && smp_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge fclk) begin
        if (ayres) begin
            out1_q <= '0;
            out2_q <= '0;
            outm_q <= '0;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            if (conv_vld_q) begin
                out1_q <= s1_q;
                out2_q <= s2_q;
                outm_q <= outm_d;
            end
            vld_q <= vld_d;
            ovr_q <= ovr_d;
        end
    end

    assign smp_valid = vld_q;
    assign smp1      = out1_q;
    assign smp2      = out2_q;
    assign smp_mix   = outm_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_ym_dac_decoder.sv
// Directed bench for ym_dac_decoder: table of decoded frames plus sequences for
// reset, overrun and framing errors.
module tb_ym_dac_decoder;

    logic               fclk = 1'b0;
    logic               ayres = 1'b1;
    logic               bit_en = 1'b0;
    logic               op1 = 1'b0;
    logic               op2 = 1'b0;
    logic               sh = 1'b0;
    logic               fm_mute = 1'b0;
    logic               smp_ready = 1'b1;
    logic               smp_valid;
    logic signed [15:0] smp1, smp2, smp_mix;
    logic               overrun, frame_err;

    int n_vec = 0;
    int n_bad = 0;

    ym_dac_decoder #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
        .fclk      (fclk),
        .ayres     (ayres),
        .bit_en    (bit_en),
        .op1       (op1),
        .op2       (op2),
        .sh        (sh),
        .fm_mute   (fm_mute),
        .smp_ready (smp_ready),
        .smp_valid (smp_valid),
        .smp1      (smp1),
        .smp2      (smp2),
        .smp_mix   (smp_mix),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 fclk = ~fclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [9:0]  m1;
        logic [2:0]  e1;
        logic [9:0]  m2;
        logic [2:0]  e2;
        logic        mute;
        logic [15:0] x1;
        logic [15:0] x2;
        logic [15:0] xm;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mkf(input logic [9:0] m, input logic [2:0] e);
        return {e, m, 3'b000};
    endfunction

    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    // One serial bit followed by a gap, as the YM clock is much slower than fclk
    task automatic send_bit(input logic b1, input logic b2, input logic s);
        op1    = b1;
        op2    = b2;
        sh     = s;
        bit_en = 1'b1;
        step();
        bit_en = 1'b0;
        sh     = 1'b0;
        repeat (3) step();
    endtask

    task automatic send_frame(input logic [15:0] f1, input logic [15:0] f2);
        for (int i = 0; i < 16; i++)
            send_bit(f1[i], f2[i], i == 15);
    endtask

    task automatic pulse_reset();
        ayres = 1'b1;
        step();
        ayres = 1'b0;
    endtask

    initial begin
        logic [15:0] fa, fb;

        tbl[0] = '{10'h300, 3'd3, 10'h200, 3'd1, 1'b0, 16'h0400, 16'h0000, 16'h0400};
        tbl[1] = '{10'h000, 3'd7, 10'h000, 3'd7, 1'b0, 16'h8000, 16'h8000, 16'h8000};
        tbl[2] = '{10'h3C0, 3'd7, 10'h3C0, 3'd7, 1'b0, 16'h7000, 16'h7000, 16'h7FFF};
        tbl[3] = '{10'h300, 3'd3, 10'h300, 3'd3, 1'b1, 16'h0000, 16'h0000, 16'h0000};
        tbl[4] = '{10'h155, 3'd0, 10'h3FF, 3'd2, 1'b0, 16'h0000, 16'h03FE, 16'h03FE};
        tbl[5] = '{10'h100, 3'd4, 10'h2AA, 3'd5, 1'b0, 16'hF800, 16'h0AA0, 16'h02A0};

        repeat (3) step();
        ayres = 1'b0;
        check("reset smp_valid", {15'd0, smp_valid}, 16'd0);
        check("reset smp1", smp1, 16'h0000);
        check("reset smp2", smp2, 16'h0000);
        check("reset smp_mix", smp_mix, 16'h0000);
        check("reset overrun", {15'd0, overrun}, 16'd0);
        check("reset frame_err", {15'd0, frame_err}, 16'd0);

        // Table: each frame checked for latency, then decoded values
        for (int v = 0; v < 6; v++) begin
            fm_mute = tbl[v].mute;
            send_frame(mkf(tbl[v].m1, tbl[v].e1), mkf(tbl[v].m2, tbl[v].e2));
            check($sformatf("v%0d valid early", v), {15'd0, smp_valid}, 16'd0);
            step();
            check($sformatf("v%0d valid", v), {15'd0, smp_valid}, 16'd1);
            check($sformatf("v%0d smp1", v), smp1, tbl[v].x1);
            check($sformatf("v%0d smp2", v), smp2, tbl[v].x2);
            check($sformatf("v%0d smp_mix", v), smp_mix, tbl[v].xm);
            step();
            check($sformatf("v%0d valid drop", v), {15'd0, smp_valid}, 16'd0);
        end
        fm_mute = 1'b0;
        check("table frame_err", {15'd0, frame_err}, 16'd0);
        check("table overrun", {15'd0, overrun}, 16'd0);

        // Overrun: two frames while downstream stalls
        smp_ready = 1'b0;
        send_frame(mkf(10'h300, 3'd3), mkf(10'h200, 3'd1));
        repeat (2) step();
        check("stall first valid", {15'd0, smp_valid}, 16'd1);
        check("stall first smp1", smp1, 16'h0400);
        check("stall first overrun", {15'd0, overrun}, 16'd0);
        send_frame(mkf(10'h100, 3'd4), mkf(10'h2AA, 3'd5));
        repeat (2) step();
        check("stall second valid", {15'd0, smp_valid}, 16'd1);
        check("stall second smp1", smp1, 16'hF800);
        check("stall second smp_mix", smp_mix, 16'h02A0);
        check("stall overrun", {15'd0, overrun}, 16'd1);
        smp_ready = 1'b1;
        step();
        check("release valid", {15'd0, smp_valid}, 16'd0);
        check("release overrun sticky", {15'd0, overrun}, 16'd1);

        // sh at cnt=10 discards the frame
        fa = mkf(10'h300, 3'd3);
        for (int i = 0; i <= 10; i++)
            send_bit(fa[i], fa[i], i == 10);
        repeat (4) step();
        check("early sh frame_err", {15'd0, frame_err}, 16'd1);
        check("early sh no valid", {15'd0, smp_valid}, 16'd0);

        pulse_reset();
        check("rst clears frame_err", {15'd0, frame_err}, 16'd0);
        check("rst clears overrun", {15'd0, overrun}, 16'd0);

        // 20 bits without sh, then sh completes the frame held at cnt=15
        fa = mkf(10'h300, 3'd3);
        fb = mkf(10'h3C0, 3'd7);
        for (int i = 0; i < 5; i++)
            send_bit(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++)
            send_bit(fa[i], fb[i], 1'b0);
        check("missing sh frame_err", {15'd0, frame_err}, 16'd1);
        check("missing sh no valid", {15'd0, smp_valid}, 16'd0);
        send_bit(fa[15], fb[15], 1'b1);
        step();
        check("late sh valid", {15'd0, smp_valid}, 16'd1);
        check("late sh smp1", smp1, 16'h0400);
        check("late sh smp2", smp2, 16'h7000);
        check("late sh smp_mix", smp_mix, 16'h7400);

        // Reset in the middle of a frame
        fa = mkf(10'h100, 3'd4);
        fb = mkf(10'h2AA, 3'd5);
        for (int i = 0; i < 8; i++)
            send_bit(fa[i], fb[i], 1'b0);
        pulse_reset();
        check("midrst smp_valid", {15'd0, smp_valid}, 16'd0);
        check("midrst smp1", smp1, 16'h0000);
        check("midrst smp2", smp2, 16'h0000);
        check("midrst smp_mix", smp_mix, 16'h0000);
        check("midrst frame_err", {15'd0, frame_err}, 16'd0);
        send_frame(fa, fb);
        step();
        check("post rst valid", {15'd0, smp_valid}, 16'd1);
        check("post rst smp1", smp1, 16'hF800);
        check("post rst smp2", smp2, 16'h0AA0);
        check("post rst smp_mix", smp_mix, 16'h02A0);
        check("post rst frame_err", {15'd0, frame_err}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
